// File: rtl/uart_rx_cfg_if.sv
// Receiver-to-consumer handshake bundle for uart_rx_cfg.
// master: driven by the receiver (word, valid, status flags, overrun pulse),
//         samples rx_ready.
// slave : consumer side, drives rx_ready and samples everything else.
interface uart_rx_cfg_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 frame_err;
  logic                 parity_err;
  logic                 break_det;
  logic                 overrun;

  modport master (
    output rx_data, rx_valid, frame_err, parity_err, break_det, overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, frame_err, parity_err, break_det, overrun,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver with input synchroniser, 3-sample majority vote,
// false-start rejection, valid/ready holding register and line status.
// Ports:
//   clk        - single clock, all logic on posedge
//   rst_n      - synchronous active-low reset
//   rxd        - asynchronous serial input, idle high
//   rx_enabled - 0 holds the receiver flushed, same as reset
//   rx         - master side of uart_rx_cfg_if: rx_data/rx_valid/status out,
//                rx_ready in; overrun is a one-cycle pulse per dropped frame
module uart_rx_cfg #(
  parameter int unsigned CLK_FREQUENCY = 1000000,
  parameter int unsigned BAUD_RATE     = 19200,
  parameter int unsigned DATA_BITS     = 8,
  parameter int unsigned PARITY        = 0,
  parameter int unsigned STOP_BITS     = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rxd,
  input  logic          rx_enabled,
  uart_rx_cfg_if.master rx
);

  localparam int unsigned BAUDDIV = CLK_FREQUENCY / BAUD_RATE;
  localparam int unsigned MID     = BAUDDIV / 2;
  localparam int unsigned CW      = $clog2(BAUDDIV);

  localparam logic [CW-1:0] CNT_LAST  = CW'(BAUDDIV - 1);
  localparam logic [CW-1:0] CNT_MID   = CW'(MID - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRKWAIT} state_t;

  state_t               state, state_n;
  logic                 clr;
  logic                 sync1, rxs;
  logic [2:0]           hist;
  logic                 vote;
  logic [CW-1:0]        cnt;
  logic [3:0]           bitcnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_err_r, ferr_r, zero_r;
  logic                 tick, done, stop_bad, frame_zero;

  assign clr  = !rst_n || !rx_enabled;
  assign vote = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);

  always_comb begin
    state_n    = state;
    tick       = 1'b0;
    done       = 1'b0;
    // Running flags including the sample being taken this cycle.
    stop_bad   = ferr_r | ~vote;
    frame_zero = zero_r & ~vote;
    case (state)
      IDLE: if (!rxs) state_n = START;
      START: begin
        tick = (cnt == CNT_MID);
        if (tick) state_n = vote ? IDLE : DATA;
      end
      DATA: begin
        tick = (cnt == CNT_LAST);
        if (tick && bitcnt == DATA_LAST) state_n = (PARITY != 0) ? PAR : STOP;
      end
      PAR: begin
        tick = (cnt == CNT_LAST);
        if (tick) state_n = STOP;
      end
      STOP: begin
        tick = (cnt == CNT_LAST);
        // Leave at the last stop sample rather than the bit end so the next
        // start edge is never missed.
        if (tick && bitcnt == STOP_LAST) begin
          done    = 1'b1;
          state_n = frame_zero ? BRKWAIT : IDLE;
        end
      end
      BRKWAIT: if (rxs) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      sync1         <= 1'b1;
      rxs           <= 1'b1;
      hist          <= '1;
      state         <= IDLE;
      cnt           <= '0;
      bitcnt        <= '0;
      shreg         <= '0;
      par_err_r     <= 1'b0;
      ferr_r        <= 1'b0;
      zero_r        <= 1'b0;
      rx.rx_data    <= '0;
      rx.rx_valid   <= 1'b0;
      rx.frame_err  <= 1'b0;
      rx.parity_err <= 1'b0;
      rx.break_det  <= 1'b0;
      rx.overrun    <= 1'b0;
    end else begin
      sync1 <= rxd;
      rxs   <= sync1;
      hist  <= {hist[1:0], rxs};
      state <= state_n;

      if (state == IDLE || state == BRKWAIT || tick) cnt <= '0;
      else                                           cnt <= cnt + 1'b1;

      if (tick) bitcnt <= (state_n != state) ? '0 : bitcnt + 4'd1;

      if (state == START && tick) begin
        par_err_r <= 1'b0;
        ferr_r    <= 1'b0;
        zero_r    <= 1'b1;
      end
      if ((state == DATA || state == PAR || state == STOP) && tick)
        zero_r <= frame_zero;
      if (state == DATA && tick) shreg <= {vote, shreg[DATA_BITS-1:1]};
      if (state == PAR && tick)
        par_err_r <= ((^shreg) ^ vote) != (PARITY == 1);
      if (state == STOP && tick) ferr_r <= stop_bad;

      rx.overrun <= 1'b0;
      if (done) begin
        if (!rx.rx_valid || rx.rx_ready) begin
          rx.rx_data    <= shreg;
          rx.rx_valid   <= 1'b1;
          rx.frame_err  <= stop_bad;
          rx.parity_err <= par_err_r;
          rx.break_det  <= frame_zero;
        end else begin
          rx.overrun <= 1'b1;
        end
      end else if (rx.rx_valid && rx.rx_ready) begin
        rx.rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
`timescale 1ns/1ps
module tb_uart_rx_cfg;

  localparam int NDUT = 5;
  localparam int CFG_DB  [NDUT] = '{8, 7, 7, 8, 9};
  localparam int CFG_PAR [NDUT] = '{0, 2, 1, 0, 2};
  localparam int CFG_SB  [NDUT] = '{1, 1, 1, 2, 2};

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NDUT-1:0] rxd, en, ready;
  logic [NDUT-1:0] o_valid, o_ferr, o_perr, o_brk, o_ovr;
  logic [8:0]      o_data [NDUT];

  int unsigned cyc = 0;
  int unsigned t_start;
  int unsigned rise_cyc [NDUT];
  int unsigned ovr_cnt  [NDUT];
  logic [NDUT-1:0] pv = '0;

  int n_checks = 0;
  int n_errors = 0;
  int spike_at = -1;

  bit          line_q[$];
  logic [31:0] exp_data;
  bit          exp_perr, exp_ferr, exp_brk;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    uart_rx_cfg_if #(.DATA_BITS(CFG_DB[g])) bus ();
    uart_rx_cfg #(
      .CLK_FREQUENCY(1000000), .BAUD_RATE(19200), .DATA_BITS(CFG_DB[g]),
      .PARITY(CFG_PAR[g]), .STOP_BITS(CFG_SB[g])
    ) dut (
      .clk(clk), .rst_n(rst_n), .rxd(rxd[g]), .rx_enabled(en[g]), .rx(bus)
    );
    assign bus.rx_ready = ready[g];
    assign o_data[g]    = 9'(bus.rx_data);
    assign o_valid[g]   = bus.rx_valid;
    assign o_ferr[g]    = bus.frame_err;
    assign o_perr[g]    = bus.parity_err;
    assign o_brk[g]     = bus.break_det;
    assign o_ovr[g]     = bus.overrun;
  end

  always @(negedge clk) begin
    for (int i = 0; i < NDUT; i++) begin
      if (o_valid[i] && !pv[i]) rise_cyc[i] = cyc;
      ovr_cnt[i] += 32'(o_ovr[i]);
    end
    pv = o_valid;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference frame: line levels start..stop plus the expected status.
  task automatic build(input int u, input logic [31:0] word, input bit pf, input logic [1:0] sm);
    int ones;
    bit p;
    line_q.delete();
    line_q.push_back(1'b0);
    exp_data = word & ((32'd1 << CFG_DB[u]) - 32'd1);
    for (int i = 0; i < CFG_DB[u]; i++) line_q.push_back(exp_data[i]);
    ones     = $countones(exp_data);
    exp_perr = 1'b0;
    if (CFG_PAR[u] != 0) begin
      p = ((ones % 2) == 1) ^ (CFG_PAR[u] == 1) ^ pf;
      line_q.push_back(p);
      exp_perr = pf;
    end
    exp_ferr = 1'b0;
    for (int i = 0; i < CFG_SB[u]; i++) begin
      line_q.push_back(!sm[i]);
      if (sm[i]) exp_ferr = 1'b1;
    end
    exp_brk = 1'b1;
    for (int i = 1; i < line_q.size(); i++) if (line_q[i]) exp_brk = 1'b0;
  endtask

  // A low final bit is cut short so the line is idle well before the
  // receiver's post-frame start detection samples it.
  task automatic send_line(input int u);
    int k;
    int n;
    @(negedge clk);
    t_start = cyc;
    k = 0;
    foreach (line_q[i]) begin
      n = (i == line_q.size() - 1 && !line_q[i]) ? 36 : 52;
      for (int j = 0; j < n; j++) begin
        rxd[u] = (k == spike_at) ? 1'b0 : line_q[i];
        k++;
        @(negedge clk);
      end
    end
    rxd[u] = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_frame(input int u, input string tag);
    int n;
    n = 0;
    while (!o_valid[u] && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 32'(o_valid[u]), 32'd1);
    check({tag, "_data"},  32'(o_data[u]),  exp_data);
    check({tag, "_perr"},  32'(o_perr[u]),  32'(exp_perr));
    check({tag, "_ferr"},  32'(o_ferr[u]),  32'(exp_ferr));
    check({tag, "_brk"},   32'(o_brk[u]),   32'(exp_brk));
  endtask

  task automatic consume(input int u);
    ready[u] = 1'b1;
    @(negedge clk);
    ready[u] = 1'b0;
    check("consume_valid", 32'(o_valid[u]), 32'd0);
  endtask

  initial begin
    int unsigned ob;
    logic [31:0] w;
    int m;
    bit pf;
    logic [1:0] sm;

    rst_n = 1'b0; en = '1; rxd = '1; ready = '0;
    idle(4);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_flags", 32'({o_ferr, o_perr, o_brk, o_ovr}), 32'd0);
    check("rst_data",  32'(o_data[4]), 32'd0);
    rst_n = 1'b1;
    idle(10);

    // 8N1 0xA5 and first-valid latency from the line edge.
    build(0, 32'hA5, 1'b0, 2'b00);
    send_line(0);
    idle(60);
    check_frame(0, "a5");
    check("a5_latency", rise_cyc[0] - t_start, 32'd497);
    consume(0);

    // False start, then a one-clock spike in the middle of data bit 3.
    rxd[0] = 1'b0; idle(20); rxd[0] = 1'b1;
    idle(600);
    check("false_start_valid", 32'(o_valid[0]), 32'd0);
    build(0, 32'hFF, 1'b0, 2'b00);
    spike_at = 4 * 52 + 26;
    send_line(0);
    spike_at = -1;
    idle(60);
    check_frame(0, "spike");
    consume(0);

    // Parity: 7E1 and 7O1 with each parity-bit value on 0x03.
    for (int u = 1; u <= 2; u++) begin
      for (int f = 0; f < 2; f++) begin
        build(u, 32'h03, f[0], 2'b00);
        send_line(u);
        idle(60);
        check_frame(u, "par03");
        consume(u);
      end
    end

    // Stop bit low, then a held-low break.
    build(0, 32'h55, 1'b0, 2'b01);
    send_line(0);
    idle(60);
    check_frame(0, "stop0");
    consume(0);
    rxd[0] = 1'b0;
    idle(600);
    check("brk_valid", 32'(o_valid[0]), 32'd1);
    check("brk_flags", 32'({o_brk[0], o_ferr[0], o_perr[0]}), 32'b110);
    check("brk_data",  32'(o_data[0]), 32'd0);
    consume(0);
    idle(300);
    check("brk_hold_low", 32'(o_valid[0]), 32'd0);
    rxd[0] = 1'b1;
    idle(100);
    check("brk_release", 32'(o_valid[0]), 32'd0);
    build(0, 32'hC3, 1'b0, 2'b00);
    send_line(0);
    idle(60);
    check_frame(0, "after_brk");
    consume(0);

    // Overrun: second frame dropped while the first is unread.
    ob = ovr_cnt[0];
    build(0, 32'h11, 1'b0, 2'b00); send_line(0); idle(60);
    build(0, 32'h22, 1'b0, 2'b00); send_line(0); idle(60);
    check("ovr_keep_data", 32'(o_data[0]), 32'h11);
    check("ovr_keep_valid", 32'(o_valid[0]), 32'd1);
    check("ovr_pulse_len", ovr_cnt[0] - ob, 32'd1);
    consume(0);

    // Accept in the completion cycle of the next frame: replace, no overrun.
    build(0, 32'h33, 1'b0, 2'b00); send_line(0); idle(60);
    ob = ovr_cnt[0];
    build(0, 32'h44, 1'b0, 2'b00);
    fork
      send_line(0);
      begin
        @(negedge clk);
        idle(496);
        ready[0] = 1'b1;
        @(negedge clk);
        ready[0] = 1'b0;
      end
    join
    idle(60);
    check_frame(0, "same_cycle");
    check("same_cycle_ovr", ovr_cnt[0] - ob, 32'd0);
    consume(0);

    // Mid-frame reset and disable on 8N2, then a clean 0x3C.
    build(3, 32'h77, 1'b0, 2'b00); send_line(3); idle(60);
    check("pre_rst_valid", 32'(o_valid[3]), 32'd1);
    rxd[3] = 1'b0; idle(150);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rxd[3] = 1'b1;
    check("mid_rst_valid", 32'(o_valid), 32'd0);
    check("mid_rst_data",  32'(o_data[3]), 32'd0);
    idle(700);
    check("post_rst_quiet", 32'(o_valid[3]), 32'd0);
    build(3, 32'h66, 1'b0, 2'b00); send_line(3); idle(60);
    rxd[3] = 1'b0; idle(150);
    en[3] = 1'b0;
    @(negedge clk);
    en[3] = 1'b1;
    rxd[3] = 1'b1;
    check("dis_valid", 32'(o_valid[3]), 32'd0);
    check("dis_flags", 32'({o_data[3], o_ferr[3], o_perr[3], o_brk[3]}), 32'd0);
    idle(700);
    check("post_dis_quiet", 32'(o_valid[3]), 32'd0);
    build(3, 32'h3C, 1'b0, 2'b00); send_line(3); idle(60);
    check_frame(3, "x3c");
    consume(3);

    // Randomised frames on every configuration.
    for (int u = 0; u < NDUT; u++) begin
      for (int f = 0; f < 8; f++) begin
        w = $urandom;
        m = int'($urandom_range(0, 9));
        pf = 1'b0;
        sm = 2'b00;
        if (m == 0) begin
          w  = '0;
          pf = (CFG_PAR[u] == 1);
          sm = 2'b11;
        end else if (m == 1) begin
          sm = (CFG_SB[u] == 2) ? 2'($urandom_range(1, 3)) : 2'b01;
        end else if (m == 2 && CFG_PAR[u] != 0) begin
          pf = 1'b1;
        end
        build(u, w, pf, sm);
        send_line(u);
        idle(60 + int'($urandom_range(0, 30)));
        check_frame(u, "rand");
        consume(u);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
